// File: rtl/regfile_pkg.sv
// Shared defaults and architectural register indices for the multi-port register file.
package regfile_pkg;

  parameter int unsigned DEFAULT_DATA_WIDTH = 32;
  parameter int unsigned DEFAULT_ADDR_WIDTH = 5;
  parameter int unsigned DEFAULT_MEM_SIZE   = 32;
  parameter int unsigned DEFAULT_NUM_READ   = 3;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_FP   = 30;
  localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/regfile_read_port.sv
// One synchronous read port: range check, r0 forcing, optional write bypass
// (REGFILE_BYPASS_EN) and registered data/busy outputs.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE   = DEFAULT_MEM_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] regs_i [MEM_SIZE],
  input  logic [MEM_SIZE-1:0]   busy_i,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] waddr0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] waddr1_i,
`ifdef REGFILE_BYPASS_EN
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
`endif
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  logic                  in_range;
  logic                  is_zero;
  logic                  hit0;
  logic                  hit1;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_busy;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  busy_d;

  assign in_range = 32'(addr_i) < MEM_SIZE;
  assign is_zero  = 32'(addr_i) == REG_ZERO;
  assign hit0     = we0_i && (waddr0_i == addr_i);
  assign hit1     = we1_i && (waddr1_i == addr_i);

  // Select the addressed entry, then apply r0/range forcing, bypass and write-clear of busy.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    for (int unsigned r = 0; r < MEM_SIZE; r++) begin
      if (32'(addr_i) == r) begin
        rd_data = regs_i[r];
        rd_busy = busy_i[r];
      end
    end
    data_d = '0;
    busy_d = 1'b0;
    if (in_range && !is_zero) begin
      data_d = rd_data;
`ifdef REGFILE_BYPASS_EN
      if (hit1) begin
        data_d = wdata1_i;
      end else if (hit0) begin
        data_d = wdata0_i;
      end
`endif
      // A write in flight retires the producer; a same-cycle lock is not yet visible.
      busy_d = rd_busy && !(hit0 || hit1);
    end
  end

  // Output registers for read data and busy flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= '0;
      busy_o <= 1'b0;
    end else begin
      data_o <= data_d;
      busy_o <= busy_d;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ read ports, two prioritised write ports
// (port 1 wins), busy scoreboard and flattened dump. Define REGFILE_BYPASS_EN
// to forward same-cycle write data to the read ports.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE   = DEFAULT_MEM_SIZE,
  parameter int unsigned NUM_READ   = DEFAULT_NUM_READ
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
  output logic [NUM_READ-1:0]            oBusy,
  input  logic                           iWriteEnable0,
  input  logic [ADDR_WIDTH-1:0]          iWriteAddress0,
  input  logic [DATA_WIDTH-1:0]          iDataIn0,
  input  logic                           iWriteEnable1,
  input  logic [ADDR_WIDTH-1:0]          iWriteAddress1,
  input  logic [DATA_WIDTH-1:0]          iDataIn1,
  input  logic                           iLockEnable,
  input  logic [ADDR_WIDTH-1:0]          iLockAddress,
  output logic [MEM_SIZE-1:0]            oBusyMask,
  output logic [MEM_SIZE*DATA_WIDTH-1:0] oRegDump
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [MEM_SIZE];
  logic [MEM_SIZE-1:0]   busy_q;
  logic [MEM_SIZE-1:0]   busy_d;

  // Next-state for storage and scoreboard; r0 is skipped so it stays zero and never busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int unsigned r = 1; r < MEM_SIZE; r++) begin
      if (iWriteEnable1 && (32'(iWriteAddress1) == r)) begin
        mem_d[r]  = iDataIn1;
        busy_d[r] = 1'b0;
      end else if (iWriteEnable0 && (32'(iWriteAddress0) == r)) begin
        mem_d[r]  = iDataIn0;
        busy_d[r] = 1'b0;
      end
      // Lock applied after the clear: the newly issued producer wins.
      if (iLockEnable && (32'(iLockAddress) == r)) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  // Storage and scoreboard state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned r = 0; r < MEM_SIZE; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign oBusyMask = busy_q;

  for (genvar r = 0; r < MEM_SIZE; r++) begin : g_dump
    assign oRegDump[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[r];
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_SIZE   (MEM_SIZE)
    ) u_read_port (
      .clk_i    (Clock),
      .rst_ni   (Reset_n),
      .addr_i   (iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .regs_i   (mem_q),
      .busy_i   (busy_q),
      .we0_i    (iWriteEnable0),
      .waddr0_i (iWriteAddress0),
      .we1_i    (iWriteEnable1),
      .waddr1_i (iWriteAddress1),
`ifdef REGFILE_BYPASS_EN
      .wdata0_i (iDataIn0),
      .wdata1_i (iDataIn1),
`endif
      .data_o   (oDataOut[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy_o   (oBusy[k])
    );
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Multi-port CPU register file. It is the parametrised successor of the single-write, three-read register file. It provides NUM_READ synchronous read ports, two prioritised write ports, optional write-to-read bypass, and a per-register busy scoreboard for the issue stage of the pipelined core. Register 0 is hardwired to zero. A flattened register dump replaces the per-register visibility outputs for the debug/display path.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width
- MEM_SIZE, 32, number of registers; must satisfy 2 ≤ MEM_SIZE ≤ 2**ADDR_WIDTH
- NUM_READ, 3, number of read ports (1..8)

Ports:
- Clock  in  1  single clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- iReadAddress  in  NUM_READ*ADDR_WIDTH  read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- oDataOut  out  NUM_READ*DATA_WIDTH  registered read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- oBusy  out  NUM_READ  registered busy flag of each read port's register
- iWriteEnable0 / iWriteAddress0 / iDataIn0  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 0
- iWriteEnable1 / iWriteAddress1 / iDataIn1  in  1 / ADDR_WIDTH / DATA_WIDTH  write port 1; higher priority
- iLockEnable  in  1  marks iLockAddress busy (an instruction issued that will write it)
- iLockAddress  in  ADDR_WIDTH  register to lock
- oBusyMask  out  MEM_SIZE  current scoreboard, bit r = register r busy
- oRegDump  out  MEM_SIZE*DATA_WIDTH  current contents, register r at [r*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Storage: exactly MEM_SIZE entries. Addresses ≥ MEM_SIZE read as 0. Writes and locks to those addresses are ignored.
- Register 0 reads 0 and is never busy. Writes and locks to address 0 are dropped.
- Writes take effect on the rising edge when the write enable is set. If both ports target the same address in the same cycle, port 1's data is stored.
- Scoreboard:
  - A lock sets busy[iLockAddress] at the edge.
  - Any enabled write clears busy[address] at the edge.
  - If a lock and a write target the same address in the same cycle, busy ends up set (the new producer wins).
  - Locking an already-busy register keeps it busy.
- Read port k samples at each edge:
  - oDataOut[k] gets the register contents before the edge, plus bypass (see Configuration).
  - oBusy[k] gets busy[addr] after the same-edge write clear and before the same-edge lock. A write in flight clears the reported busy flag. A lock in the same cycle does not set it.
- oBusyMask and oRegDump are combinational views of the state after the edge.
- Reset (asynchronous, any time, including mid-write): all registers = 0, all busy = 0, oDataOut = 0, oBusy = 0. The first edge after Reset_n rises operates normally.

## Timing
- Read latency is 1 cycle: the address presented in cycle n gives data on oDataOut after edge n.
- Write-to-storage latency is 1 edge. Lock-to-oBusyMask latency is 1 edge.
- Reading in cycle n+1 a register written in cycle n returns the new data, with or without bypass.
- There is no stall or handshake; every port is accepted every cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If port k's address equals an enabled write address in the same cycle, oDataOut[k] takes that write's data.
  - If both write ports match, port 1 wins.
  - Address 0 is never bypassed.
- REGFILE_BYPASS_EN undefined: oDataOut[k] returns the pre-edge contents (old value). This is the legacy read-during-write behaviour.
- The busy-flag clearing rule in Operation is independent of the macro.

## Structure
- Package regfile_pkg holds:
  - default widths (DATA_WIDTH, ADDR_WIDTH, MEM_SIZE, NUM_READ)
  - register index constants REG_ZERO=0, REG_SP=29, REG_FP=30, REG_RA=31
- Sub-module regfile_read_port, instantiated NUM_READ times in a generate loop. Each instance contains:
  - the address range check
  - the zero-register forcing
  - the bypass compare (under REGFILE_BYPASS_EN)
  - the output registers for data and busy, with async reset
- The top level holds the storage array, write priority logic and scoreboard.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert Reset_n=0 mid-cycle → oRegDump is all 0, oBusyMask=0, oDataOut=0 immediately, without waiting for an edge.
- Write priority: port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle; read r7 the next cycle → 0x22. Writing r0=0xFF → r0 reads 0.
- Bypass: read r3 (holding 0x5) while writing r3=0xA in the same cycle → oDataOut=0xA with REGFILE_BYPASS_EN, 0x5 without it. Read r3 in the next cycle → 0xA in both builds.
- Scoreboard:
  - Lock r9 → oBusyMask[9]=1 after one edge.
  - Read r9 → oBusy=1.
  - Write r9 while reading it → oBusy=0 and busy cleared.
  - Lock and write r9 in the same cycle → busy remains 1.
- Out-of-range: with MEM_SIZE=20, writing r25=0x1 is ignored and reading r25 → 0. Locking r0 → oBusyMask unchanged.
- Multi-port: NUM_READ=4 reading r1..r4 (preloaded 1..4) simultaneously → each port returns its own value with 1-cycle latency.
